// File: rtl/trap_controller_if.sv
// Core-side request bus and CSR-file port of the trap controller.
// slave = the controller; master = core pipeline plus CSR file.
interface trap_controller_if;
  logic        trap_request;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_request;
  logic        inst_csr_write_enable;
  logic [11:0] inst_csr_write_address;
  logic [31:0] inst_csr_write_data;
  logic [11:0] inst_csr_read_address;
  logic [31:0] csr_read_out;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic [11:0] csr_read_address;
  logic        trapped;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_target;
  logic        pipeline_stall;

  modport slave (
    input  trap_request, trap_cause, trap_pc, mret_request,
    input  inst_csr_write_enable, inst_csr_write_address, inst_csr_write_data,
    input  inst_csr_read_address, csr_read_out,
    output csr_write_enable, csr_write_address, csr_write_data, csr_read_address,
    output trapped, pc_redirect_valid, pc_redirect_target, pipeline_stall
  );

  modport master (
    output trap_request, trap_cause, trap_pc, mret_request,
    output inst_csr_write_enable, inst_csr_write_address, inst_csr_write_data,
    output inst_csr_read_address, csr_read_out,
    input  csr_write_enable, csr_write_address, csr_write_data, csr_read_address,
    input  trapped, pc_redirect_valid, pc_redirect_target, pipeline_stall
  );
endinterface

// File: rtl/trap_controller.sv
// Trap/MRET sequencer owning the M-mode CSR port: trap = 4 cycles to redirect, MRET = 2.
// Requests are not queued; pipeline_stall holds the requester until the sequence returns to IDLE.
module trap_controller #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic             clk,
  input logic             reset,
  trap_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_MEPC   = 3'd1;
  localparam logic [2:0] S_WR_MCAUSE = 3'd2;
  localparam logic [2:0] S_RD_MTVEC  = 3'd3;
  localparam logic [2:0] S_RD_MEPC   = 3'd4;
  localparam logic [2:0] S_REDIRECT  = 3'd5;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  logic [2:0]  state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:2] target_q, target_d;
  logic        trap_flag_q, trap_flag_d;

  logic [31:0] mtvec_base;
  logic        vec_hit;
  logic [31:0] trap_target;

  assign mtvec_base  = {bus.csr_read_out[31:2], 2'b00};
  assign vec_hit     = VECTORED_EN && (bus.csr_read_out[1:0] == 2'b01) && cause_q[31];
  // Vector offset is cause*4; bit 30 of the cause shifts out of the 32-bit sum.
  assign trap_target = vec_hit ? (mtvec_base + {cause_q[29:0], 2'b00}) : mtvec_base;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    target_d    = target_q;
    trap_flag_d = trap_flag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.trap_request) begin
          pc_d    = bus.trap_pc[31:2];
          cause_d = bus.trap_cause;
          state_d = S_WR_MEPC;
        end else if (bus.mret_request) begin
          state_d = S_RD_MEPC;
        end
      end
      S_WR_MEPC:   state_d = S_WR_MCAUSE;
      S_WR_MCAUSE: state_d = S_RD_MTVEC;
      S_RD_MTVEC: begin
        target_d    = trap_target[31:2];
        trap_flag_d = 1'b1;
        state_d     = S_REDIRECT;
      end
      S_RD_MEPC: begin
        target_d    = bus.csr_read_out[31:2];
        trap_flag_d = 1'b0;
        state_d     = S_REDIRECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      target_q    <= '0;
      trap_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      target_q    <= target_d;
      trap_flag_q <= trap_flag_d;
    end
  end

  always_comb begin
    bus.csr_write_enable   = 1'b0;
    bus.csr_write_address  = '0;
    bus.csr_write_data     = '0;
    bus.csr_read_address   = '0;
    bus.trapped            = 1'b0;
    bus.pc_redirect_valid  = 1'b0;
    bus.pc_redirect_target = '0;
    case (state_q)
      S_IDLE: begin
        // The trapping instruction's own CSR write must never commit.
        bus.csr_write_enable  = bus.inst_csr_write_enable & ~bus.trap_request;
        bus.csr_write_address = bus.inst_csr_write_address;
        bus.csr_write_data    = bus.inst_csr_write_data;
        bus.csr_read_address  = bus.inst_csr_read_address;
      end
      S_WR_MEPC: begin
        bus.csr_write_enable  = 1'b1;
        bus.csr_write_address = CSR_MEPC;
        bus.csr_write_data    = {pc_q, 2'b00};
      end
      S_WR_MCAUSE: begin
        bus.csr_write_enable  = 1'b1;
        bus.csr_write_address = CSR_MCAUSE;
        bus.csr_write_data    = cause_q;
      end
      S_RD_MTVEC: bus.csr_read_address = CSR_MTVEC;
      S_RD_MEPC:  bus.csr_read_address = CSR_MEPC;
      S_REDIRECT: begin
        bus.pc_redirect_valid  = 1'b1;
        bus.pc_redirect_target = {target_q, 2'b00};
        bus.trapped            = trap_flag_q;
      end
      default: ;
    endcase
    if (reset) begin
      bus.csr_write_enable   = 1'b0;
      bus.pc_redirect_valid  = 1'b0;
      bus.pc_redirect_target = '0;
      bus.trapped            = 1'b0;
    end
  end

  assign bus.pipeline_stall = ((state_q != S_IDLE) & ~reset) | bus.trap_request | bus.mret_request;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench: CSR file model, scripted-sequence reference model, per-cycle compare.
module tb_trap_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_controller_if bus ();
  trap_controller_if bus2 ();

  trap_controller #(.VECTORED_EN(1'b1)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  trap_controller #(.VECTORED_EN(1'b0)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // CSR file environment: combinational read, write on rising edge.
  logic [31:0] csr_mem [4096];
  always @(posedge clk) if (bus.csr_write_enable) csr_mem[bus.csr_write_address] <= bus.csr_write_data;
  assign bus.csr_read_out  = csr_mem[bus.csr_read_address];
  assign bus2.csr_read_out = csr_mem[bus2.csr_read_address];

  assign bus2.trap_request           = bus.trap_request;
  assign bus2.trap_cause             = bus.trap_cause;
  assign bus2.trap_pc                = bus.trap_pc;
  assign bus2.mret_request           = bus.mret_request;
  assign bus2.inst_csr_write_enable  = bus.inst_csr_write_enable;
  assign bus2.inst_csr_write_address = bus.inst_csr_write_address;
  assign bus2.inst_csr_write_data    = bus.inst_csr_write_data;
  assign bus2.inst_csr_read_address  = bus.inst_csr_read_address;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a trap or MRET is a script of per-cycle actions.
  localparam int A_WR = 0, A_RTVEC = 1, A_REPC = 2, A_REDIR = 3;
  typedef struct { int kind; logic [11:0] addr; logic [31:0] data; } act_t;
  act_t        plan [$];
  logic [31:0] m_cause, m_target, m_target_nv, base;
  logic        m_flag;
  act_t        a;

  always @(negedge clk) begin
    if (reset) begin
      chk("we_rst", {31'd0, bus.csr_write_enable}, 32'd0);
      chk("rv_rst", {31'd0, bus.pc_redirect_valid}, 32'd0);
      chk("trapped_rst", {31'd0, bus.trapped}, 32'd0);
      chk("target_rst", bus.pc_redirect_target, 32'd0);
      chk("stall_rst", {31'd0, bus.pipeline_stall}, {31'd0, bus.trap_request | bus.mret_request});
      plan.delete();
    end else if (plan.size() == 0) begin
      chk("we_idle", {31'd0, bus.csr_write_enable},
          {31'd0, bus.inst_csr_write_enable & ~bus.trap_request});
      if (bus.inst_csr_write_enable && !bus.trap_request) begin
        chk("wa_idle", {20'd0, bus.csr_write_address}, {20'd0, bus.inst_csr_write_address});
        chk("wd_idle", bus.csr_write_data, bus.inst_csr_write_data);
      end
      chk("ra_idle", {20'd0, bus.csr_read_address}, {20'd0, bus.inst_csr_read_address});
      chk("rv_idle", {31'd0, bus.pc_redirect_valid}, 32'd0);
      chk("stall_idle", {31'd0, bus.pipeline_stall}, {31'd0, bus.trap_request | bus.mret_request});
      if (bus.trap_request) begin
        m_cause = bus.trap_cause;
        plan.push_back('{A_WR, 12'h341, bus.trap_pc & 32'hFFFF_FFFC});
        plan.push_back('{A_WR, 12'h342, bus.trap_cause});
        plan.push_back('{A_RTVEC, 12'h0, 32'h0});
        plan.push_back('{A_REDIR, 12'h0, 32'h0});
      end else if (bus.mret_request) begin
        plan.push_back('{A_REPC, 12'h0, 32'h0});
        plan.push_back('{A_REDIR, 12'h0, 32'h0});
      end
    end else begin
      a = plan.pop_front();
      chk("stall_seq", {31'd0, bus.pipeline_stall}, 32'd1);
      chk("we_seq", {31'd0, bus.csr_write_enable}, (a.kind == A_WR) ? 32'd1 : 32'd0);
      if (a.kind == A_WR) begin
        chk("wa_seq", {20'd0, bus.csr_write_address}, {20'd0, a.addr});
        chk("wd_seq", bus.csr_write_data, a.data);
      end
      chk("ra_seq", {20'd0, bus.csr_read_address},
          (a.kind == A_RTVEC) ? 32'h305 : (a.kind == A_REPC) ? 32'h341 : 32'h0);
      chk("rv_seq", {31'd0, bus.pc_redirect_valid}, (a.kind == A_REDIR) ? 32'd1 : 32'd0);
      chk("trapped_seq", {31'd0, bus.trapped}, (a.kind == A_REDIR && m_flag) ? 32'd1 : 32'd0);
      chk("target_seq", bus.pc_redirect_target, (a.kind == A_REDIR) ? m_target : 32'd0);
      chk("target_nv_seq", bus2.pc_redirect_target, (a.kind == A_REDIR) ? m_target_nv : 32'd0);
      if (a.kind == A_RTVEC) begin
        base        = csr_mem[12'h305] & 32'hFFFF_FFFC;
        m_target_nv = base;
        m_target    = (csr_mem[12'h305][1:0] == 2'b01 && m_cause[31])
                      ? base + (m_cause & 32'h7FFF_FFFF) * 32'd4 : base;
        m_flag      = 1'b1;
      end else if (a.kind == A_REPC) begin
        m_target    = csr_mem[12'h341] & 32'hFFFF_FFFC;
        m_target_nv = m_target;
        m_flag      = 1'b0;
      end
    end
  end

  // Per-run statistics gathered on the falling edge.
  int          cyc, redir_at, redir_cnt, trapped_cnt, stall_cnt;
  logic [31:0] redir_tgt, redir_tgt2;

  task automatic clear_stats();
    cyc = 0; redir_at = -1; redir_cnt = 0; trapped_cnt = 0; stall_cnt = 0;
    redir_tgt = '0; redir_tgt2 = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.pc_redirect_valid) begin
      redir_at = cyc; redir_cnt++;
      redir_tgt = bus.pc_redirect_target; redir_tgt2 = bus2.pc_redirect_target;
    end
    if (bus.trapped) trapped_cnt++;
    if (bus.pipeline_stall) stall_cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] ad, input logic [31:0] d);
    bus.inst_csr_write_enable = 1'b1; bus.inst_csr_write_address = ad; bus.inst_csr_write_data = d;
    tick();
    bus.inst_csr_write_enable = 1'b0;
  endtask

  task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause, input int n);
    clear_stats();
    bus.trap_request = 1'b1; bus.trap_pc = pc; bus.trap_cause = cause;
    tick();
    bus.trap_request = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.trap_request = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0; bus.mret_request = 1'b0;
    bus.inst_csr_write_enable = 1'b1; bus.inst_csr_write_address = 12'h305;
    bus.inst_csr_write_data = 32'hDEAD_BEEF; bus.inst_csr_read_address = 12'h300;
    clear_stats();
    repeat (2) tick();
    chk("lit_reset_redirects", redir_cnt, 0);
    reset = 1'b0;
    bus.inst_csr_write_enable = 1'b0;

    csr_wr(12'h300, 32'h0000_AAAA);
    csr_wr(12'h305, 32'h0000_1000);
    chk("lit_idle_passthrough", csr_mem[12'h300], 32'h0000_AAAA);

    // Direct trap with a same-cycle instruction write and a write during WR_MCAUSE.
    clear_stats();
    bus.trap_request = 1'b1; bus.trap_pc = 32'h0000_0204; bus.trap_cause = 32'h2;
    bus.inst_csr_write_enable = 1'b1; bus.inst_csr_write_address = 12'h305;
    bus.inst_csr_write_data = 32'h0000_5000;
    tick();
    bus.trap_request = 1'b0; bus.inst_csr_write_enable = 1'b0;
    tick();
    bus.inst_csr_write_enable = 1'b1; bus.inst_csr_write_address = 12'h300;
    bus.inst_csr_write_data = 32'h0000_1234;
    tick();
    bus.inst_csr_write_enable = 1'b0;
    repeat (4) tick();
    chk("lit_direct_at", redir_at, 4);
    chk("lit_direct_tgt", redir_tgt, 32'h0000_1000);
    chk("lit_direct_trapped", trapped_cnt, 1);
    chk("lit_direct_stall", stall_cnt, 5);
    chk("lit_mepc", csr_mem[12'h341], 32'h0000_0204);
    chk("lit_mcause", csr_mem[12'h342], 32'h0000_0002);
    chk("lit_mtvec_kept", csr_mem[12'h305], 32'h0000_1000);
    chk("lit_wr_in_seq_ignored", csr_mem[12'h300], 32'h0000_AAAA);

    csr_wr(12'h305, 32'h0000_3001);
    run_trap(32'h0000_0300, 32'h8000_0007, 5);
    chk("lit_vec_tgt", redir_tgt, 32'h0000_301C);
    chk("lit_vec_off_tgt", redir_tgt2, 32'h0000_3000);
    run_trap(32'h0000_0308, 32'h0000_0003, 5);
    chk("lit_exc_mode01_tgt", redir_tgt, 32'h0000_3000);
    csr_wr(12'h305, 32'h0000_3003);
    run_trap(32'h0000_0310, 32'h8000_0005, 5);
    chk("lit_mode11_tgt", redir_tgt, 32'h0000_3000);

    csr_wr(12'h341, 32'h0000_4002);
    clear_stats();
    bus.mret_request = 1'b1;
    tick();
    bus.mret_request = 1'b0;
    repeat (3) tick();
    chk("lit_mret_at", redir_at, 2);
    chk("lit_mret_tgt", redir_tgt, 32'h0000_4000);
    chk("lit_mret_trapped", trapped_cnt, 0);
    chk("lit_mret_stall", stall_cnt, 3);
    chk("lit_mret_mcause", csr_mem[12'h342], 32'h8000_0005);

    // Trap and MRET together: trap wins, held MRET starts on the first IDLE cycle.
    clear_stats();
    bus.trap_request = 1'b1; bus.mret_request = 1'b1;
    bus.trap_pc = 32'h0000_0500; bus.trap_cause = 32'h0000_000B;
    tick();
    bus.trap_request = 1'b0;
    repeat (5) tick();
    bus.mret_request = 1'b0;
    repeat (3) tick();
    chk("lit_both_redirects", redir_cnt, 2);
    chk("lit_both_mret_at", redir_at, 7);
    chk("lit_both_mret_tgt", redir_tgt, 32'h0000_0500);
    chk("lit_both_trapped", trapped_cnt, 1);

    // Reset during WR_MCAUSE.
    clear_stats();
    bus.trap_request = 1'b1; bus.trap_pc = 32'h0000_0700; bus.trap_cause = 32'h9;
    tick();
    bus.trap_request = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("lit_rst_mepc", csr_mem[12'h341], 32'h0000_0700);
    chk("lit_rst_mcause", csr_mem[12'h342], 32'h0000_000B);
    chk("lit_rst_redirects", redir_cnt, 0);
    chk("lit_rst_stall", stall_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer and port arbiter for the machine-mode CSR file in the RV32 core. Converts trap requests (exceptions, ECALL/EBREAK, interrupts) and MRET into ordered CSR accesses: write mepc, write mcause, read mtvec (or read mepc for MRET). Issues a PC redirect to fetch and owns the CSR file's single read/write port, so instruction-issued CSR accesses are only passed through when no trap sequence is active.

## Interface
- VECTORED_EN, 1: 1 enables mtvec vectored mode (MODE=01) for interrupts; 0 always uses direct mode.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears FSM and all latched registers.
- trap_request  in  1  trap pending this cycle; sampled only in IDLE.
- trap_cause  in  32  mcause value; bit 31 = interrupt.
- trap_pc  in  32  PC of the trapping instruction.
- mret_request  in  1  MRET retiring; sampled only in IDLE.
- inst_csr_write_enable  in  1  CSR write from the instruction path.
- inst_csr_write_address  in  12  instruction-path write address.
- inst_csr_write_data  in  32  instruction-path write data.
- inst_csr_read_address  in  12  instruction-path read address.
- csr_read_out  in  32  CSR file read data; combinational from csr_read_address.
- csr_write_enable  out  1  to CSR file.
- csr_write_address  out  12  to CSR file.
- csr_write_data  out  32  to CSR file.
- csr_read_address  out  12  to CSR file.
- trapped  out  1  to CSR file trapped input; one-cycle pulse on trap redirect.
- pc_redirect_valid  out  1  one-cycle pulse: fetch loads pc_redirect_target.
- pc_redirect_target  out  32  redirect PC; word-aligned.
- pipeline_stall  out  1  holds upstream stages during a sequence.

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIRECT.
- IDLE: CSR port is a combinational passthrough of the inst_csr_* signals. trap_request -> latch trap_pc/trap_cause, go to WR_MEPC. Otherwise mret_request -> RD_MEPC. If both are asserted, the trap wins and MRET is dropped.
- Trap-cycle suppression: in IDLE with trap_request=1, csr_write_enable is forced 0, so the faulting instruction's CSR write never commits.
- WR_MEPC: write 0x341 with {pc_l[31:2],2'b00}; -> WR_MCAUSE.
- WR_MCAUSE: write 0x342 with cause_l; -> RD_MTVEC.
- RD_MTVEC: read 0x305; target_l = base {csr_read_out[31:2],2'b00}.
  - If VECTORED_EN=1, csr_read_out[1:0]==01 and cause_l[31]=1: target_l = base + (cause_l[30:0]<<2), truncated to 32 bits.
  - MODE 10/11 is treated as direct.
  - -> REDIRECT, set trap flag.
- RD_MEPC: read 0x341; target_l = {csr_read_out[31:2],2'b00}; -> REDIRECT, clear trap flag.
- REDIRECT: pc_redirect_valid=1; pc_redirect_target=target_l; trapped=trap flag; -> IDLE.
- Outside IDLE:
  - inst_csr_* inputs are ignored.
  - csr_write_enable=0 except in WR_MEPC and WR_MCAUSE.
  - csr_read_address is FSM-driven (0x305/0x341), otherwise 0x000.
- pipeline_stall = (state!=IDLE) | trap_request | mret_request. Combinational, so the request cycle itself stalls.
- Requests arriving during a sequence are not queued. The stalled requester holds them until IDLE.

## Timing
- Trap: request sampled at edge 0. Edge 0 -> WR_MEPC, edge 1 -> WR_MCAUSE, edge 2 -> RD_MTVEC, edge 3 -> REDIRECT, edge 4 -> IDLE.
  - Redirect pulse is visible in the cycle between edges 3 and 4.
  - mepc and mcause are committed by edges 1 and 2, before mtvec is read.
- MRET: edge 0 -> RD_MEPC, edge 1 -> REDIRECT; pulse between edges 1 and 2.
- Back-to-back: a request present in the cycle after REDIRECT (state IDLE) starts immediately. Minimum trap-to-trap spacing is 5 cycles.
- Reset values: state IDLE, latches 0.
  - csr_write_enable=0 while reset=1, regardless of inputs.
  - trapped=0, pc_redirect_valid=0, pc_redirect_target=0.
  - pipeline_stall reflects only requests in IDLE.
- Reset mid-sequence: next edge returns to IDLE, and the sequence is abandoned.
  - Writes already committed stay committed; no redirect is issued.
  - A write in the reset cycle itself is suppressed.

## Test plan
- Direct trap: mtvec=0x00001000, trap_pc=0x00000204, cause=0x2 -> mepc=0x00000204, mcause=0x2, redirect to 0x00001000 exactly 4 cycles after request; trapped pulses 1 cycle; stall high for 5 cycles.
- Vectored interrupt: mtvec=0x00003001, cause=0x80000007 -> redirect to 0x0000301C; same cause with VECTORED_EN=0 -> 0x00003000; exception cause=0x3 with MODE=01 -> 0x00003000.
- MRET: mepc=0x00004002 -> redirect 0x00004000 two cycles after request; trapped stays 0; mcause unchanged.
- Arbitration:
  - inst write 0x305 <- 0x5000 in the same cycle as trap_request -> write dropped, mtvec unchanged.
  - inst write during WR_MCAUSE -> ignored.
  - inst write in IDLE -> passes through.
- Simultaneous trap_request and mret_request -> trap sequence only; held mret_request after return -> MRET sequence starts on the first IDLE cycle.
- Reset asserted in WR_MCAUSE -> mepc written, mcause not written; no redirect; state IDLE; all outputs at reset values.
